flags_register: RTL and testbench

- Holds the CPU status flags: Overflow, Sign, Zero, CarryA and CarryL.
- Captures the flag outputs of the ALU when an ALU op completes.
- Supports save/restore of the flags over MainBus, acting as both bus reader and bus writer.
- Evaluates the branch condition selected by the pipeline for the jump logic.
- Feeds the registered logic carry back to the ALU LCarryIn, closing the carry loop.

---
 rtl/flags_register.sv | 107 ++++++++++
 tb/tb_flags_register.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/flags_register.sv
// flags_register: CPU status flags (Overflow, Sign, Zero, CarryA, CarryL).
// Captures ALU flags, saves/restores them over MainBus, evaluates the
// pipeline's branch condition and feeds the registered logic carry back
// to the ALU.  Flag bit order everywhere is {CarryL, CarryA, Zero, Sign, Overflow}.
//
// There is no FSM and no valid/ready handshake here: every control input is
// a level sampled at the rising edge (Stall > Flags_Load > AluActive > hold),
// and the bus driver is purely combinational.
module flags_register #(
    parameter logic       BYPASS      = 1'b0,
    parameter logic [4:0] RESET_FLAGS = 5'b00000
) (
    input  logic       Clock,
    input  logic       Reset,
    inout  wire  [7:0] MainBus,
    input  logic       Flags_0_Overflow,
    input  logic       Flags_1_Sign,
    input  logic       Flags_2_Zero,
    input  logic       Flags_3_CarryA,
    input  logic       Flags_4_CarryL,
    input  logic       AluActive,
    input  logic [4:0] FlagWriteMask,
    input  logic       Flags_Load,
    input  logic       Flags_Assert,
    input  logic       Stall,
    input  logic [3:0] Cond,
    output logic       CondMet,
    output logic [4:0] FlagsOut,
    output logic       LCarryOut
);

    logic [4:0] r_flags;
    logic       r_cond_met;
    logic [4:0] w_alu_flags;
    logic [4:0] w_flags_next;
    logic [4:0] w_dec_flags;
    logic       w_cond_next;
    logic       w_bus_drive;

    assign w_alu_flags = {Flags_4_CarryL, Flags_3_CarryA, Flags_2_Zero,
                          Flags_1_Sign, Flags_0_Overflow};

    // Branch condition decode over a flag vector.
    function automatic logic f_decode(input logic [3:0] cond, input logic [4:0] f);
        logic o, s, z, ca, cl, lt;
        o  = f[0];
        s  = f[1];
        z  = f[2];
        ca = f[3];
        cl = f[4];
        lt = s ^ o;
        case (cond)
            4'd0:    f_decode = o;
            4'd1:    f_decode = !o;
            4'd2:    f_decode = s;
            4'd3:    f_decode = !s;
            4'd4:    f_decode = z;
            4'd5:    f_decode = !z;
            4'd6:    f_decode = ca;
            4'd7:    f_decode = !ca;
            4'd8:    f_decode = cl;
            4'd9:    f_decode = !cl;
            4'd10:   f_decode = lt;
            4'd11:   f_decode = !lt;
            4'd12:   f_decode = lt | z;
            4'd13:   f_decode = !(lt | z);
            4'd14:   f_decode = 1'b1;
            default: f_decode = 1'b0;
        endcase
    endfunction

    // Next-state flags: stall holds, bus load beats ALU capture, masked ALU merge.
    always_comb begin
        w_flags_next = r_flags;
        if (Stall) begin
            w_flags_next = r_flags;
        end else if (!Flags_Load) begin
            w_flags_next = MainBus[4:0];
        end else if (AluActive) begin
            w_flags_next = (FlagWriteMask & w_alu_flags) | (~FlagWriteMask & r_flags);
        end
    end

    // Forwarding choice: decode on next-state flags (BYPASS) or on the register.
    assign w_dec_flags = BYPASS ? w_flags_next : r_flags;
    assign w_cond_next = Stall ? r_cond_met : f_decode(Cond, w_dec_flags);

    // Flag and condition registers; reset discards any pending update at once.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_flags    <= RESET_FLAGS;
            r_cond_met <= 1'b0;
        end else begin
            r_flags    <= w_flags_next;
            r_cond_met <= w_cond_next;
        end
    end

    // Bus driver: only registered flags, and never while loading (no self-loop).
    assign w_bus_drive = !Flags_Assert && Flags_Load && Reset;
    assign MainBus     = w_bus_drive ? {3'b000, r_flags} : 8'hzz;

    assign FlagsOut  = r_flags;
    assign CondMet   = r_cond_met;
    assign LCarryOut = r_flags[4];

endmodule

// File: tb/tb_flags_register.sv
// Bench for flags_register: one DUT with BYPASS=0 and one with BYPASS=1 share
// all inputs. A reference model pushes {CondMet_bypass, CondMet_reg, flags}
// into exp_q when a cycle is driven; the entry is popped after the edge.
module tb_flags_register;

    logic       Clock;
    logic       Reset;
    logic       f_o, f_s, f_z, f_ca, f_cl;
    logic       AluActive;
    logic [4:0] FlagWriteMask;
    logic       Flags_Load;
    logic       Flags_Assert;
    logic       Stall;
    logic [3:0] Cond;
    logic [7:0] bus_drv;
    logic       bus_en;
    wire  [7:0] bus0;
    wire  [7:0] bus1;
    logic       cm0, cm1;
    logic [4:0] fo0, fo1;
    logic       lc0, lc1;

    assign bus0 = bus_en ? bus_drv : 8'hzz;
    assign bus1 = bus_en ? bus_drv : 8'hzz;

    flags_register #(.BYPASS(1'b0), .RESET_FLAGS(5'b00000)) dut0 (
        .Clock(Clock), .Reset(Reset), .MainBus(bus0),
        .Flags_0_Overflow(f_o), .Flags_1_Sign(f_s), .Flags_2_Zero(f_z),
        .Flags_3_CarryA(f_ca), .Flags_4_CarryL(f_cl),
        .AluActive(AluActive), .FlagWriteMask(FlagWriteMask),
        .Flags_Load(Flags_Load), .Flags_Assert(Flags_Assert),
        .Stall(Stall), .Cond(Cond),
        .CondMet(cm0), .FlagsOut(fo0), .LCarryOut(lc0)
    );

    flags_register #(.BYPASS(1'b1), .RESET_FLAGS(5'b00000)) dut1 (
        .Clock(Clock), .Reset(Reset), .MainBus(bus1),
        .Flags_0_Overflow(f_o), .Flags_1_Sign(f_s), .Flags_2_Zero(f_z),
        .Flags_3_CarryA(f_ca), .Flags_4_CarryL(f_cl),
        .AluActive(AluActive), .FlagWriteMask(FlagWriteMask),
        .Flags_Load(Flags_Load), .Flags_Assert(Flags_Assert),
        .Stall(Stall), .Cond(Cond),
        .CondMet(cm1), .FlagsOut(fo1), .LCarryOut(lc1)
    );

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];
    logic [4:0] m_flags;
    logic       m_cm0, m_cm1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
        logic lt;
        lt = f[1] ^ f[0];
        case (c)
            4'd0: return f[0];
            4'd1: return ~f[0];
            4'd2: return f[1];
            4'd3: return ~f[1];
            4'd4: return f[2];
            4'd5: return ~f[2];
            4'd6: return f[3];
            4'd7: return ~f[3];
            4'd8: return f[4];
            4'd9: return ~f[4];
            4'd10: return lt;
            4'd11: return ~lt;
            4'd12: return lt | f[2];
            4'd13: return ~(lt | f[2]);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Driver tasks
    task automatic set_idle();
        Stall = 0; AluActive = 0; FlagWriteMask = 5'b00000;
        Flags_Load = 1; Flags_Assert = 1; bus_en = 0; bus_drv = 8'h00;
        {f_cl, f_ca, f_z, f_s, f_o} = 5'b00000;
        Cond = 4'd15;
    endtask

    task automatic set_alu(input logic [4:0] mask, input logic [4:0] af);
        AluActive = 1; FlagWriteMask = mask;
        {f_cl, f_ca, f_z, f_s, f_o} = af;
    endtask

    task automatic set_load(input logic [7:0] v);
        Flags_Load = 0; bus_en = 1; bus_drv = v;
    endtask

    // Drive one cycle: push the model's expectation, clock, pop and compare.
    task automatic tick();
        logic [4:0] nf;
        logic       n0, n1;
        logic [6:0] e;
        nf = m_flags;
        if (!Stall) begin
            if (!Flags_Load) nf = bus_drv[4:0];
            else if (AluActive)
                nf = (FlagWriteMask & {f_cl, f_ca, f_z, f_s, f_o}) | (~FlagWriteMask & m_flags);
        end
        n0 = Stall ? m_cm0 : ref_cond(Cond, m_flags);
        n1 = Stall ? m_cm1 : ref_cond(Cond, nf);
        exp_q.push_back({n1, n0, nf});
        m_flags = nf; m_cm0 = n0; m_cm1 = n1;
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        check("flags_b0", {3'b000, fo0}, {3'b000, e[4:0]});
        check("flags_b1", {3'b000, fo1}, {3'b000, e[4:0]});
        check("condmet_b0", {7'b0, cm0}, {7'b0, e[5]});
        check("condmet_b1", {7'b0, cm1}, {7'b0, e[6]});
        check("lcarry_b0", {7'b0, lc0}, {7'b0, e[4]});
        check("lcarry_b1", {7'b0, lc1}, {7'b0, e[4]});
    endtask

    initial begin
        Reset = 0;
        set_idle();
        m_flags = 5'b00000; m_cm0 = 0; m_cm1 = 0;
        #12;
        check("reset_flags", {3'b000, fo0}, 8'h00);
        check("reset_condmet", {7'b0, cm0}, 8'h00);
        check("reset_lcarry", {7'b0, lc1}, 8'h00);
        Reset = 1;
        @(posedge Clock); #1;

        // Cond=14 -> CondMet=1
        Cond = 4'd14; tick();
        check("cond14", {7'b0, cm0}, 8'h01);

        // ALU capture of Zero, then Cond=4 (bypass sees it one edge earlier)
        set_alu(5'b11111, 5'b00100); Cond = 4'd4; tick();
        set_idle(); Cond = 4'd4; tick();

        // Masked update keeps CarryL/CarryA
        set_load(8'h1F); tick();
        set_idle(); set_alu(5'b00111, 5'b00000); tick();
        set_idle();
        check("masked_flags", {3'b000, fo0}, 8'h18);

        // Assert registered flags on the bus; then bus must be released
        set_load(8'h0A); tick();
        set_idle(); Flags_Assert = 0; #1;
        check("assert_bus_b0", bus0, 8'h0A);
        check("assert_bus_b1", bus1, 8'h0A);
        set_alu(5'b11111, 5'b11111); #1;
        check("assert_not_alu", bus0, 8'h0A);
        set_idle(); bus_en = 1; bus_drv = 8'h15; #1;
        check("release_bus", bus0, 8'h15);
        bus_en = 0;

        // Illegal assert+load: driver suppressed, external value loaded
        set_load(8'hF5); Flags_Assert = 0; #1;
        check("suppress_bus", bus0, 8'hF5);
        tick();
        set_idle();
        check("load_f5", {3'b000, fo0}, 8'h15);

        // Load beats ALU; then stall freezes everything
        set_load(8'h01); set_alu(5'b11111, 5'b11110); Cond = 4'd0; tick();
        set_idle(); Stall = 1; set_alu(5'b11111, 5'b11110); Cond = 4'd1; tick();
        check("stall_hold", {3'b000, fo1}, 8'h01);
        set_idle();

        // Signed conditions: S=1 O=0 Z=0, then S=1 O=1
        set_load(8'h02); tick(); set_idle();
        Cond = 4'd10; tick();
        Cond = 4'd12; tick();
        Cond = 4'd13; tick();
        set_load(8'h03); tick(); set_idle();
        Cond = 4'd11; tick();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            set_idle();
            Stall = ($urandom_range(0, 7) == 0);
            Cond = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) set_load(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) set_alu(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (Flags_Load && $urandom_range(0, 3) == 0) begin
                Flags_Assert = 0; #1;
                check("rand_bus", bus0, {3'b000, m_flags});
            end
            tick();
        end

        // Asynchronous reset mid-cycle
        set_idle(); set_load(8'h1F); tick();
        set_idle(); Cond = 4'd14; tick();
        #2; Reset = 0; #1;
        check("async_flags", {3'b000, fo0}, 8'h00);
        check("async_condmet", {7'b0, cm1}, 8'h00);
        check("async_lcarry", {7'b0, lc0}, 8'h00);
        @(posedge Clock); #1;
        check("reset_held", {3'b000, fo1}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
